// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: takes words over valid/ready and streams them
// one bit per clock on w, back-to-back when the source keeps up.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | no word in flight; w held at IDLE_LEVEL, ready for a new word
//  SHIFT | word in flight; w carries bit cnt, next word accepted on last bit
module serial_word_feeder #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             flush,
    output logic             w,
    output logic             w_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             w_nxt;
    logic             w_valid_nxt;
    logic             busy_nxt;
    logic             word_done_nxt;
    logic             last_bit;
    logic             accept;

    // Bit that leaves the word first, and the word with that bit consumed.
    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    assign last_bit   = (state == SHIFT) && (cnt == LAST);
    assign load_ready = reset & ~flush & ((state == IDLE) | last_bit);
    assign accept     = load_valid & load_ready;

    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh;
        cnt_nxt       = cnt;
        w_nxt         = w;
        w_valid_nxt   = w_valid;
        busy_nxt      = busy;
        word_done_nxt = word_done;

        if (flush || (state == SHIFT && last_bit && !accept)) begin
            state_nxt     = IDLE;
            cnt_nxt       = '0;
            w_nxt         = IDLE_LEVEL;
            w_valid_nxt   = 1'b0;
            busy_nxt      = 1'b0;
            word_done_nxt = 1'b0;
        end else if (accept) begin
            // Shift register keeps only the bits still to be sent.
            state_nxt     = SHIFT;
            sh_nxt        = advance(load_data);
            cnt_nxt       = '0;
            w_nxt         = head(load_data);
            w_valid_nxt   = 1'b1;
            busy_nxt      = 1'b1;
            word_done_nxt = (LAST == '0);
        end else if (state == SHIFT) begin
            sh_nxt        = advance(sh);
            cnt_nxt       = cnt + 1'b1;
            w_nxt         = head(sh);
            word_done_nxt = (cnt_nxt == LAST);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            w         <= IDLE_LEVEL;
            w_valid   <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            sh        <= sh_nxt;
            cnt       <= cnt_nxt;
            w         <= w_nxt;
            w_valid   <= w_valid_nxt;
            busy      <= busy_nxt;
            word_done <= word_done_nxt;
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: MSB-first and LSB-first instances share stimulus
// and are checked against a word/bit-index reference model.
module tb_serial_word_feeder;

    logic       clock;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       flush;

    logic ready_m, w_m, wv_m, busy_m, done_m;
    logic ready_l, w_l, wv_l, busy_l, done_l;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: captured word and index of the bit currently on w (-1 = idle).
    int         idx  = -1;
    logic [7:0] word = 8'h00;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_m), .flush(flush), .w(w_m), .w_valid(wv_m), .busy(busy_m),
        .word_done(done_m)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_l), .flush(flush), .w(w_l), .w_valid(wv_l), .busy(busy_l),
        .word_done(done_l)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input bit msb);
        if (idx < 0) return 1'b0;
        return msb ? word[7 - idx] : word[idx];
    endfunction

    task automatic check_outputs();
        chk("w_msb",         w_m,    exp_bit(1'b1));
        chk("w_lsb",         w_l,    exp_bit(1'b0));
        chk("w_valid_msb",   wv_m,   idx >= 0);
        chk("w_valid_lsb",   wv_l,   idx >= 0);
        chk("busy_msb",      busy_m, idx >= 0);
        chk("busy_lsb",      busy_l, idx >= 0);
        chk("word_done_msb", done_m, idx == 7);
        chk("word_done_lsb", done_l, idx == 7);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        bit m_ready;
        check_outputs();
        load_valid = v;
        load_data  = d;
        flush      = f;
        #1;
        m_ready = !f && (idx < 0 || idx == 7);
        chk("load_ready_msb", ready_m, m_ready);
        chk("load_ready_lsb", ready_l, m_ready);
        @(posedge clock);
        if (f)                   idx = -1;
        else if (v && m_ready) begin
            word = d;
            idx  = 0;
        end else if (idx >= 0)   idx = (idx == 7) ? -1 : idx + 1;
        @(negedge clock);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        logic [7:0] seq;

        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        flush      = 1'b0;
        #1;
        check_outputs();
        chk("reset_ready_msb", ready_m, 1'b0);
        chk("reset_ready_lsb", ready_l, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        idle_steps(2);

        // Test 1: 8'hB0 MSB-first, explicit sequence, then idle.
        step(1'b1, 8'hB0, 1'b0);
        seq = 8'b10110000;
        for (int i = 0; i < 8; i++) begin
            chk("t1_seq", w_m, seq[7 - i]);
            chk("t1_done", done_m, i == 7);
            step(1'b0, 8'($urandom), 1'b0);
        end
        chk("t1_idle_w", w_m, 1'b0);
        chk("t1_idle_busy", busy_m, 1'b0);
        idle_steps(1);

        // Test 2: A5 then 3C held by the source, streamed with no gap.
        step(1'b1, 8'hA5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("t2_wv_contig", wv_m, 1'b1);
            step(1'b1, 8'h3C, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            chk("t2_wv_contig", wv_m, 1'b1);
            step(1'b0, 8'h00, 1'b0);
        end
        idle_steps(1);

        // Test 3: 8'h0D LSB-first gives 1,0,1,1,0,0,0,0.
        step(1'b1, 8'h0D, 1'b0);
        seq = 8'b10110000;
        for (int i = 0; i < 8; i++) begin
            chk("t3_seq", w_l, seq[7 - i]);
            step(1'b0, 8'($urandom), 1'b0);
        end

        // Test 4: flush with load_valid during bit 3 of 8'hFF.
        step(1'b1, 8'hFF, 1'b0);
        idle_steps(3);
        chk("t4_bit3", w_m, 1'b1);
        step(1'b1, 8'h5A, 1'b1);
        chk("t4_flushed_wv", wv_m, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        chk("t4_reload_wv", wv_m, 1'b1);
        idle_steps(9);

        // Test 5: asynchronous reset between edges, mid-word.
        step(1'b1, 8'hC3, 1'b0);
        idle_steps(2);
        load_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        idx = -1;
        check_outputs();
        chk("t5_ready_msb", ready_m, 1'b0);
        @(negedge clock);
        check_outputs();
        reset = 1'b1;
        step(1'b1, 8'h81, 1'b0);
        chk("t5_restart_bit0", w_m, 1'b1);
        // Test 6: data changes right after the handshake.
        for (int i = 0; i < 9; i++) step(1'b0, 8'($urandom), 1'b0);

        // Randomised traffic with occasional flush.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
        idle_steps(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
